// File: rtl/tis_node_sequencer_if.sv
// Neighbour-port handshake bundle for a TIS node sequencer.
// master = sequencer side (drives rd_ready/wr_valid), slave = neighbour link side.
interface tis_node_sequencer_if #(
  parameter int unsigned DATA_W = 11
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (
    input  rd_valid,
    input  rd_data,
    input  wr_ready,
    output rd_ready,
    output wr_valid
  );

  modport slave (
    output rd_valid,
    output rd_data,
    output wr_ready,
    input  rd_ready,
    input  wr_valid
  );
endinterface

// File: rtl/tis_node_sequencer.sv
// Per-node TIS-100 control FSM: owns the pc, stalls on neighbour ports, strobes commits.
// Optional macro TIS_SEQ_STEP_EN adds i_step to single-step instructions in EXEC.
module tis_node_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_run,
`ifdef TIS_SEQ_STEP_EN
  input  logic                     i_step,
`endif
  input  logic [ADDR_W-1:0]        i_last_line,
  input  logic [3:0]               i_pc_instr,
  input  logic signed [DATA_W-1:0] i_const_val,
  input  logic signed [DATA_W-1:0] i_acc,
  input  logic                     i_src_port,
  input  logic                     i_dst_port,
  tis_node_sequencer_if.master     port_if,
  output logic signed [DATA_W-1:0] o_port_data,
  output logic [ADDR_W-1:0]        o_pc,
  output logic                     o_exec_en,
  output logic                     o_stall
);

  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JEZ = 4'd8;
  localparam logic [3:0] OP_JNZ = 4'd9;
  localparam logic [3:0] OP_JGZ = 4'd10;
  localparam logic [3:0] OP_JLZ = 4'd11;
  localparam logic [3:0] OP_JRO = 4'd12;
  localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

  typedef enum logic [1:0] {StExec, StRdWait, StWrWait} state_e;

  state_e                   r_state;
  logic [ADDR_W-1:0]        r_pc;
  logic                     r_rd_ready;
  logic                     r_wr_valid;
  logic                     r_exec_en;
  logic signed [DATA_W-1:0] r_port_data;

  logic                     w_adv;
  logic                     w_is_jump;
  logic                     w_taken;
  logic [ADDR_W-1:0]        w_seq_pc;
  logic [ADDR_W-1:0]        w_jmp_pc;
  logic [ADDR_W-1:0]        w_jro_pc;
  logic [ADDR_W-1:0]        w_next_pc;
  logic signed [DATA_W-1:0] w_offset;
  logic signed [DATA_W:0]   w_jro_sum;
  logic signed [DATA_W:0]   w_last_ext;

`ifdef TIS_SEQ_STEP_EN
  assign w_adv = i_run & i_step;
`else
  assign w_adv = i_run;
`endif

  assign w_offset   = i_src_port ? r_port_data : i_const_val;
  assign w_last_ext = $signed({{(DATA_W + 1 - ADDR_W){1'b0}}, i_last_line});
  assign w_jro_sum  = $signed({{(DATA_W + 1 - ADDR_W){1'b0}}, r_pc})
                    + $signed({w_offset[DATA_W-1], w_offset});

  always_comb begin
    // pc beyond last_line (last_line lowered mid-program) also wraps to 0
    w_seq_pc = (r_pc >= i_last_line) ? '0 : r_pc + PcOne;
    w_jmp_pc = (i_const_val[ADDR_W-1:0] > i_last_line) ? i_last_line
                                                        : i_const_val[ADDR_W-1:0];
    if (w_jro_sum[DATA_W]) begin
      w_jro_pc = '0;
    end else if (w_jro_sum > w_last_ext) begin
      w_jro_pc = i_last_line;
    end else begin
      w_jro_pc = w_jro_sum[ADDR_W-1:0];
    end

    w_is_jump = 1'b1;
    w_taken   = 1'b0;
    case (i_pc_instr)
      OP_JMP:  w_taken = 1'b1;
      OP_JEZ:  w_taken = (i_acc == '0);
      OP_JNZ:  w_taken = (i_acc != '0);
      OP_JGZ:  w_taken = !i_acc[DATA_W-1] && (i_acc != '0);
      OP_JLZ:  w_taken = i_acc[DATA_W-1];
      OP_JRO:  w_taken = 1'b0;
      default: w_is_jump = 1'b0;
    endcase

    if (i_pc_instr == OP_JRO) begin
      w_next_pc = w_jro_pc;
    end else if (w_taken) begin
      w_next_pc = w_jmp_pc;
    end else begin
      w_next_pc = w_seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StExec;
      r_pc        <= '0;
      r_rd_ready  <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_exec_en   <= 1'b0;
      r_port_data <= '0;
    end else begin
      r_exec_en <= 1'b0;
      unique case (r_state)
        StExec: begin
          if (w_adv) begin
            if (i_src_port) begin
              r_state    <= StRdWait;
              r_rd_ready <= 1'b1;
            end else if (i_dst_port) begin
              r_state    <= StWrWait;
              r_wr_valid <= 1'b1;
            end else begin
              r_pc      <= w_next_pc;
              r_exec_en <= ~w_is_jump;
            end
          end
        end
        StRdWait: begin
          // Transfers complete even with run low; rd_ready low afterwards marks data held
          if (r_rd_ready) begin
            if (port_if.rd_valid) begin
              r_port_data <= port_if.rd_data;
              r_rd_ready  <= 1'b0;
            end
          end else if (i_run) begin
            if (i_dst_port) begin
              r_state    <= StWrWait;
              r_wr_valid <= 1'b1;
            end else begin
              r_state   <= StExec;
              r_pc      <= w_next_pc;
              r_exec_en <= ~w_is_jump;
            end
          end
        end
        StWrWait: begin
          if (r_wr_valid) begin
            if (port_if.wr_ready) begin
              r_wr_valid <= 1'b0;
              if (i_run) begin
                r_state   <= StExec;
                r_pc      <= w_next_pc;
                r_exec_en <= ~w_is_jump;
              end
            end
          end else if (i_run) begin
            r_state   <= StExec;
            r_pc      <= w_next_pc;
            r_exec_en <= ~w_is_jump;
          end
        end
        default: r_state <= StExec;
      endcase
    end
  end

  assign port_if.rd_ready = r_rd_ready;
  assign port_if.wr_valid = r_wr_valid;
  assign o_port_data      = r_port_data;
  assign o_pc             = r_pc;
  assign o_exec_en        = r_exec_en;
  assign o_stall          = (r_state != StExec);

endmodule
